// File: rtl/turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : turn_arbiter
// Description : Tic-tac-toe turn scheduler. Arbitrates player and computer
//               moves, checks legality, strobes the position registers and
//               samples the win/draw detectors after each commit.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIRST_MOVER    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] button,
  input  logic [8:0] pc_move,
  input  logic       pc_valid,
  input  logic [8:0] occupied,
  input  logic       win,
  input  logic [1:0] who,
  input  logic       no_space,
  output logic       pc_ready,
  output logic [8:0] PL_en,
  output logic [8:0] PC_en,
  output logic       board_clr,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] move_count,
  output logic [1:0] result,
  output logic [2:0] state
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_CLEAR   = 3'd1;
  localparam logic [2:0] c_ST_WAIT_PL = 3'd2;
  localparam logic [2:0] c_ST_WAIT_PC = 3'd3;
  localparam logic [2:0] c_ST_SETTLE  = 3'd4;
  localparam logic [2:0] c_ST_CHECK   = 3'd5;
  localparam logic [2:0] c_ST_DONE    = 3'd6;

  localparam logic        c_FIRST_PC   = (FIRST_MOVER != 0);
  localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  c_MAX_MOVES  = 4'd9;

  function automatic logic f_onehot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_turn;        // side owning the current/last move: 1 = computer
  logic [15:0] r_timer;
  logic [8:0]  r_pl_en;
  logic [8:0]  r_pc_en;
  logic        r_illegal;
  logic        r_timeout;
  logic [3:0]  r_move_count;
  logic [1:0]  r_result;

  logic w_pl_legal;
  logic w_pc_legal;
  logic w_pl_hit;
  logic w_pc_hit;
  logic w_timer_exp;
  logic w_pl_commit;
  logic w_pc_commit;
  logic w_illegal_nxt;
  logic w_timeout_nxt;

  assign w_pl_legal  = f_onehot(button) && ((button & occupied) == 9'd0);
  assign w_pl_hit    = f_onehot(button) && ((button & occupied) != 9'd0);
  assign w_pc_legal  = pc_valid && f_onehot(pc_move) && ((pc_move & occupied) == 9'd0);
  assign w_pc_hit    = pc_valid && f_onehot(pc_move) && ((pc_move & occupied) != 9'd0);
  assign w_timer_exp = (r_timer == c_TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        if (start) w_state_nxt = c_ST_CLEAR;
      end
      c_ST_CLEAR: begin
        w_state_nxt = c_FIRST_PC ? c_ST_WAIT_PC : c_ST_WAIT_PL;
      end
      c_ST_WAIT_PL: begin
        if (w_pl_legal)       w_state_nxt = c_ST_SETTLE;
        else if (w_timer_exp) w_state_nxt = c_ST_WAIT_PC;
      end
      c_ST_WAIT_PC: begin
        if (w_pc_legal) w_state_nxt = c_ST_SETTLE;
      end
      c_ST_SETTLE: begin
        w_state_nxt = c_ST_CHECK;
      end
      c_ST_CHECK: begin
        if (win || no_space) w_state_nxt = c_ST_DONE;
        else                 w_state_nxt = r_turn ? c_ST_WAIT_PL : c_ST_WAIT_PC;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_ready      = (r_state == c_ST_WAIT_PC);
    board_clr     = (r_state == c_ST_CLEAR);
    w_pl_commit   = (r_state == c_ST_WAIT_PL) && w_pl_legal;
    w_pc_commit   = (r_state == c_ST_WAIT_PC) && w_pc_legal;
    w_illegal_nxt = ((r_state == c_ST_WAIT_PL) && w_pl_hit) ||
                    ((r_state == c_ST_WAIT_PC) && w_pc_hit);
    w_timeout_nxt = (r_state == c_ST_WAIT_PL) && w_timer_exp && !w_pl_legal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_turn       <= c_FIRST_PC;
      r_timer      <= 16'd0;
      r_pl_en      <= 9'd0;
      r_pc_en      <= 9'd0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      r_move_count <= 4'd0;
      r_result     <= 2'b00;
    end else begin
      r_pl_en   <= w_pl_commit ? button : 9'd0;
      r_pc_en   <= w_pc_commit ? pc_move : 9'd0;
      r_illegal <= w_illegal_nxt;
      r_timeout <= w_timeout_nxt;
      r_timer   <= (r_state == c_ST_WAIT_PL) ? r_timer + 16'd1 : 16'd0;

      if (w_state_nxt == c_ST_WAIT_PL) r_turn <= 1'b0;
      else if (w_state_nxt == c_ST_WAIT_PC) r_turn <= 1'b1;

      if (w_state_nxt == c_ST_CLEAR) begin
        r_move_count <= 4'd0;
        r_result     <= 2'b00;
      end else begin
        if ((w_pl_commit || w_pc_commit) && (r_move_count != c_MAX_MOVES)) begin
          r_move_count <= r_move_count + 4'd1;
        end
        if (r_state == c_ST_CHECK) begin
          if (win)           r_result <= who;
          else if (no_space) r_result <= 2'b11;
        end
      end
    end
  end

  assign PL_en      = r_pl_en;
  assign PC_en      = r_pc_en;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign move_count = r_move_count;
  assign result     = r_result;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_arbiter
// Description : Randomized game-level bench for turn_arbiter; the bench owns
//               the board and decides wins, the arbiter's outputs are scored.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_arbiter;

  localparam int c_TIMEOUT = 1024;
  localparam int c_FIRST   = 0;

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_CLEAR   = 3'd1;
  localparam logic [2:0] c_S_WAIT_PL = 3'd2;
  localparam logic [2:0] c_S_WAIT_PC = 3'd3;
  localparam logic [2:0] c_S_SETTLE  = 3'd4;
  localparam logic [2:0] c_S_CHECK   = 3'd5;
  localparam logic [2:0] c_S_DONE    = 3'd6;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic [8:0] button   = 9'd0;
  logic [8:0] pc_move  = 9'd0;
  logic       pc_valid = 1'b0;
  logic [8:0] occupied = 9'd0;
  logic       win      = 1'b0;
  logic [1:0] who      = 2'b00;
  logic       no_space;
  logic       pc_ready;
  logic [8:0] PL_en;
  logic [8:0] PC_en;
  logic       board_clr;
  logic       illegal;
  logic       timeout;
  logic [3:0] move_count;
  logic [1:0] result;
  logic [2:0] state;

  assign no_space = &occupied;

  turn_arbiter #(
    .TIMEOUT_CYCLES(c_TIMEOUT),
    .FIRST_MOVER   (c_FIRST)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .button    (button),
    .pc_move   (pc_move),
    .pc_valid  (pc_valid),
    .occupied  (occupied),
    .win       (win),
    .who       (who),
    .no_space  (no_space),
    .pc_ready  (pc_ready),
    .PL_en     (PL_en),
    .PC_en     (PC_en),
    .board_clr (board_clr),
    .illegal   (illegal),
    .timeout   (timeout),
    .move_count(move_count),
    .result    (result),
    .state     (state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_count;
  bit         exp_turn;      // 1 = computer to move
  bit         game_over;
  logic [1:0] exp_result;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] sq_bit(input int k);
    logic [8:0] one = 9'd1;
    return one << k;
  endfunction

  function automatic logic [8:0] pick_free();
    int s = int'($urandom_range(0, 8));
    for (int i = 0; i < 9; i++) begin
      if (!occupied[(s + i) % 9]) return sq_bit((s + i) % 9);
    end
    return 9'd0;
  endfunction

  function automatic logic [8:0] pick_taken();
    int s = int'($urandom_range(0, 8));
    for (int i = 0; i < 9; i++) begin
      if (occupied[(s + i) % 9]) return sq_bit((s + i) % 9);
    end
    return 9'd0;
  endfunction

  function automatic logic [8:0] multi_bits();
    int a = int'($urandom_range(0, 8));
    int b = (a + int'($urandom_range(1, 8))) % 9;
    return sq_bit(a) | sq_bit(b);
  endfunction

  function automatic int next_count(input int c);
    return (c < 9) ? c + 1 : 9;
  endfunction

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_state", state, c_S_CLEAR);
    chk("clr_pulse", board_clr, 1);
    occupied = 9'd0;
    tick();
    chk("clr_one_cycle", board_clr, 0);
    chk("start_state", state, (c_FIRST != 0) ? c_S_WAIT_PC : c_S_WAIT_PL);
    chk("start_count", move_count, 0);
    chk("start_result", result, 0);
    chk("start_ready", pc_ready, (c_FIRST != 0) ? 1 : 0);
    exp_count = 0;
    exp_turn  = (c_FIRST != 0);
    game_over = 1'b0;
    exp_result = 2'b00;
  endtask

  // Bench decides whether the just-committed move wins; board-full follows occupancy.
  task automatic check_phase(input bit side, input int win_prob);
    bit w;
    logic [1:0] wv;
    tick();
    chk("check_state", state, c_S_CHECK);
    chk("settle_strobes", PL_en | PC_en, 0);
    w  = (exp_count >= 3) && (int'($urandom_range(0, 99)) < win_prob);
    wv = 2'($urandom_range(1, 2));
    win = w;
    who = wv;
    tick();
    win = 1'b0;
    if (w) begin
      exp_result = wv;
      game_over  = 1'b1;
    end else if (&occupied) begin
      exp_result = 2'b11;
      game_over  = 1'b1;
    end else begin
      exp_result = 2'b00;
      exp_turn   = !side;
    end
    chk("post_check_result", result, exp_result);
    chk("post_check_state", state,
        game_over ? c_S_DONE : (exp_turn ? c_S_WAIT_PC : c_S_WAIT_PL));
  endtask

  task automatic player_commit(input logic [8:0] sq, input int win_prob);
    button = sq;
    tick();
    button = 9'd0;
    exp_count = next_count(exp_count);
    chk("pl_settle_state", state, c_S_SETTLE);
    chk("pl_strobe", PL_en, sq);
    chk("pl_no_pc_strobe", PC_en, 0);
    chk("pl_no_timeout", timeout, 0);
    chk("pl_count", move_count, exp_count);
    occupied = occupied | sq;
    check_phase(1'b0, win_prob);
  endtask

  task automatic pc_commit(input logic [8:0] sq, input int win_prob);
    pc_move  = sq;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    pc_move  = 9'd0;
    exp_count = next_count(exp_count);
    chk("pc_settle_state", state, c_S_SETTLE);
    chk("pc_strobe", PC_en, sq);
    chk("pc_no_pl_strobe", PL_en, 0);
    chk("pc_count", move_count, exp_count);
    occupied = occupied | sq;
    check_phase(1'b1, win_prob);
  endtask

  task automatic player_turn(input int win_prob);
    int n = int'($urandom_range(0, 3));
    int kind;
    bit exp_ill;
    chk("pl_turn_state", state, c_S_WAIT_PL);
    chk("pl_turn_ready", pc_ready, 0);
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 3));
      exp_ill = 1'b0;
      case (kind)
        0: button = ($urandom_range(0, 1) != 0) ? multi_bits() : 9'd0;
        1: begin
          if (occupied != 9'd0) begin
            button  = pick_taken();
            exp_ill = 1'b1;
          end else begin
            button = multi_bits();
          end
        end
        2: begin
          pc_move  = pick_free();
          pc_valid = 1'b1;
        end
        default: start = 1'b1;
      endcase
      tick();
      button = 9'd0; pc_move = 9'd0; pc_valid = 1'b0; start = 1'b0;
      chk("pl_wait_state", state, c_S_WAIT_PL);
      chk("pl_wait_illegal", illegal, exp_ill);
      chk("pl_wait_strobes", PL_en | PC_en, 0);
      chk("pl_wait_clr", board_clr, 0);
    end
    player_commit(pick_free(), win_prob);
  endtask

  task automatic pc_turn(input int win_prob);
    int n = int'($urandom_range(0, 3));
    int kind;
    bit exp_ill;
    chk("pc_turn_state", state, c_S_WAIT_PC);
    chk("pc_turn_ready", pc_ready, 1);
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 3));
      exp_ill = 1'b0;
      case (kind)
        0: pc_move = pick_free();
        1: begin
          pc_valid = 1'b1;
          pc_move  = pick_taken();
          exp_ill  = (pc_move != 9'd0);
        end
        2: button = pick_free();
        default: begin
          pc_valid = 1'b1;
          pc_move  = multi_bits();
        end
      endcase
      tick();
      button = 9'd0; pc_move = 9'd0; pc_valid = 1'b0;
      chk("pc_wait_state", state, c_S_WAIT_PC);
      chk("pc_wait_illegal", illegal, exp_ill);
      chk("pc_wait_strobes", PL_en | PC_en, 0);
    end
    pc_commit(pick_free(), win_prob);
  endtask

  task automatic play_rest(input int win_prob);
    int guard = 0;
    while (!game_over && guard < 12) begin
      if (exp_turn) pc_turn(win_prob);
      else          player_turn(win_prob);
      guard++;
    end
    chk("game_ended", game_over, 1);
  endtask

  task automatic done_checks();
    chk("done_state", state, c_S_DONE);
    chk("done_result", result, exp_result);
    button   = pick_free() | sq_bit(0);
    pc_move  = sq_bit(int'($urandom_range(0, 8)));
    pc_valid = 1'b1;
    repeat (2) tick();
    button = 9'd0; pc_move = 9'd0; pc_valid = 1'b0;
    chk("done_no_strobes", PL_en | PC_en, 0);
    chk("done_held_state", state, c_S_DONE);
    chk("done_held_result", result, exp_result);
    chk("done_held_count", move_count, exp_count);
  endtask

  initial begin
    bit bad;
    logic [8:0] sq;

    repeat (3) tick();
    chk("rst_state", state, c_S_IDLE);
    chk("rst_strobes", PL_en | PC_en, 0);
    chk("rst_count", move_count, 0);
    chk("rst_result", result, 0);
    chk("rst_pulses", {pc_ready, board_clr, illegal, timeout}, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", state, c_S_IDLE);

    // Directed opening: centre square, then a colliding computer move.
    start_game();
    player_commit(9'b000010000, 0);
    chk("pc_ready_after_pl", pc_ready, 1);
    pc_move  = 9'b000010000;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    pc_move  = 9'd0;
    chk("pc_collide_illegal", illegal, 1);
    chk("pc_collide_strobe", PC_en, 0);
    chk("pc_collide_state", state, c_S_WAIT_PC);
    tick();
    chk("pc_collide_pulse_len", illegal, 0);
    pc_commit(pick_free(), 0);

    // Idle player with a two-bit request runs the timer out.
    button = 9'b000000011;
    bad = 1'b0;
    repeat (c_TIMEOUT - 1) begin
      tick();
      if (illegal || timeout || (PL_en != 9'd0)) bad = 1'b1;
    end
    chk("idle_no_pulse", bad, 0);
    chk("pre_expiry_state", state, c_S_WAIT_PL);
    tick();
    button = 9'd0;
    chk("timeout_pulse", timeout, 1);
    chk("timeout_state", state, c_S_WAIT_PC);
    chk("timeout_count", move_count, exp_count);
    chk("timeout_no_write", PL_en, 0);
    tick();
    chk("timeout_pulse_len", timeout, 0);
    exp_turn = 1'b1;
    pc_commit(pick_free(), 0);

    // A legal move in the expiry cycle wins over the timeout.
    repeat (c_TIMEOUT - 1) tick();
    chk("expiry_edge_state", state, c_S_WAIT_PL);
    player_commit(pick_free(), 0);
    play_rest(30);
    done_checks();

    start_game();
    play_rest(100);
    done_checks();

    start_game();
    play_rest(0);
    chk("draw_result", result, 2'b11);
    chk("draw_count", move_count, 9);
    done_checks();

    repeat (4) begin
      start_game();
      play_rest(int'($urandom_range(0, 40)));
      done_checks();
    end

    // Reset during the strobe cycle kills it asynchronously.
    start_game();
    sq = pick_free();
    button = sq;
    tick();
    button = 9'd0;
    chk("pre_rst_strobe", PL_en, sq);
    occupied = occupied | sq;
    reset_n = 1'b0;
    #1;
    chk("async_rst_strobe", PL_en, 0);
    chk("async_rst_state", state, c_S_IDLE);
    chk("async_rst_count", move_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", state, c_S_IDLE);
    start_game();
    play_rest(50);
    done_checks();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
